sha256_msg_padder: RTL and testbench

//  Front end that produces the preprocessed 512-bit blocks consumed by the sha256 compression core.

---
 rtl/sha256_msg_padder.sv | 150 +++++++++++++++
 tb/tb_sha256_msg_padder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: packs a byte stream into 512-bit FIPS 180-4 blocks.
// Optional block counter output enabled by defining SHA256_PADDER_STATS_EN.
module sha256_msg_padder #(
  parameter int LEN_W = 64
`ifdef SHA256_PADDER_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic [7:0]   InData,
  input  logic         InValid,
  input  logic         InLast,
  input  logic         InEmpty,
  output logic         InReady,
  output logic [511:0] Chunk,
  output logic         ChunkValid,
  input  logic         ChunkReady,
  output logic         ChunkLast,
  output logic         MsgDone
`ifdef SHA256_PADDER_STATS_EN
  , output logic [CNT_W-1:0] BlockCnt
`endif
);

  typedef enum logic [1:0] {FILL, PAD, LEN, EMIT} state_e;

  state_e            state_q, state_d;
  state_e            ret_q, ret_d;
  logic [5:0]        ptr_q, ptr_d;
  logic [LEN_W-1:0]  bitlen_q, bitlen_d;
  logic [0:63][7:0]  buf_q, buf_d;
  logic              last_q, last_d;
  logic              done_q, done_d;
  logic [63:0]       len64;
  logic              hs;

  assign len64      = 64'(bitlen_q);
  assign hs         = (state_q == EMIT) && ChunkReady;
  assign InReady    = (state_q == FILL) && !Reset;
  assign Chunk      = buf_q;
  assign ChunkValid = (state_q == EMIT);
  assign ChunkLast  = last_q;
  assign MsgDone    = done_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= FILL;
      ret_q    <= FILL;
      ptr_q    <= '0;
      bitlen_q <= '0;
      buf_q    <= '0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ret_q    <= ret_d;
      ptr_q    <= ptr_d;
      bitlen_q <= bitlen_d;
      buf_q    <= buf_d;
      last_q   <= last_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ret_d    = ret_q;
    ptr_d    = ptr_q;
    bitlen_d = bitlen_q;
    buf_d    = buf_q;
    last_d   = last_q;
    done_d   = 1'b0;
    unique case (state_q)
      FILL: begin
        if (InValid) begin
          if (!InEmpty) begin
            buf_d[ptr_q] = InData;
            ptr_d        = ptr_q + 6'd1;
            bitlen_d     = bitlen_q + LEN_W'(8);
            if (ptr_q == 6'd63) begin
              state_d = EMIT;
              last_d  = 1'b0;
              ret_d   = InLast ? PAD : FILL;
              ptr_d   = '0;
            end else if (InLast) begin
              state_d = PAD;
            end
          end else if (InLast) begin
            state_d = PAD;
          end
        end
      end
      PAD: begin
        for (int i = 0; i < 64; i++) begin
          if (6'(i) == ptr_q)
            buf_d[i] = 8'h80;
          else if (6'(i) > ptr_q)
            buf_d[i] = 8'h00;
        end
        state_d = EMIT;
        // Length only fits if the 0x80 marker left bytes 56..63 free
        if (ptr_q <= 6'd55) begin
          buf_d[56:63] = len64;
          last_d       = 1'b1;
        end else begin
          last_d = 1'b0;
          ret_d  = LEN;
        end
      end
      LEN: begin
        buf_d        = '0;
        buf_d[56:63] = len64;
        last_d       = 1'b1;
        state_d      = EMIT;
      end
      EMIT: begin
        if (ChunkReady) begin
          ptr_d = '0;
          if (last_q) begin
            state_d  = FILL;
            bitlen_d = '0;
            done_d   = 1'b1;
          end else begin
            state_d = ret_q;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

`ifdef SHA256_PADDER_STATS_EN
  logic [CNT_W-1:0] cnt_q;

  assign BlockCnt = cnt_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      cnt_q <= '0;
    else if (hs) begin
      if (last_q)
        cnt_q <= '0;
      else if (cnt_q != {CNT_W{1'b1}})
        cnt_q <= cnt_q + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed bench for sha256_msg_padder: table of messages plus stall and
// mid-message reset sequences.
module tb_sha256_msg_padder;

  logic         Clk = 1'b0;
  logic         Reset;
  logic [7:0]   InData;
  logic         InValid;
  logic         InLast;
  logic         InEmpty;
  logic         InReady;
  logic [511:0] Chunk;
  logic         ChunkValid;
  logic         ChunkReady;
  logic         ChunkLast;
  logic         MsgDone;
`ifdef SHA256_PADDER_STATS_EN
  logic [15:0]  BlockCnt;
`endif

  sha256_msg_padder dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .InData     (InData),
    .InValid    (InValid),
    .InLast     (InLast),
    .InEmpty    (InEmpty),
    .InReady    (InReady),
    .Chunk      (Chunk),
    .ChunkValid (ChunkValid),
    .ChunkReady (ChunkReady),
    .ChunkLast  (ChunkLast),
    .MsgDone    (MsgDone)
`ifdef SHA256_PADDER_STATS_EN
    , .BlockCnt (BlockCnt)
`endif
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_cyc = -10;
  int done_cyc = -20;
  int done_n = 0;
  logic [511:0] q_blk[$];
  logic         q_last[$];
  int           q_cnt[$];

  always @(posedge Clk) begin
    cyc <= cyc + 1;
    if (ChunkValid && ChunkReady && !Reset) begin
      q_blk.push_back(Chunk);
      q_last.push_back(ChunkLast);
`ifdef SHA256_PADDER_STATS_EN
      q_cnt.push_back(int'(BlockCnt));
`else
      q_cnt.push_back(0);
`endif
      if (ChunkLast) hs_cyc <= cyc;
    end
    if (MsgDone && !Reset) begin
      done_n   <= done_n + 1;
      done_cyc <= cyc;
    end
  end

  task automatic chk(string name, logic [511:0] act, logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clr();
    q_blk.delete();
    q_last.delete();
    q_cnt.delete();
    done_n = 0;
  endtask

  task automatic send_beat(logic [7:0] d, logic last, logic empty);
    int w;
    @(negedge Clk);
    InData  = d;
    InValid = 1'b1;
    InLast  = last;
    InEmpty = empty;
    w = 0;
    while (!InReady && w < 200) begin
      @(negedge Clk);
      w++;
    end
    if (w >= 200) chk("in_ready_timeout", 1'b0, 1'b1);
    @(posedge Clk);
  endtask

  task automatic send_msg(int start, int n);
    if (n == 0)
      send_beat(8'h00, 1'b1, 1'b1);
    else
      for (int i = 0; i < n; i++)
        send_beat(8'(start + i), i == n - 1, 1'b0);
    @(negedge Clk);
    InValid = 1'b0;
    InLast  = 1'b0;
    InEmpty = 1'b0;
  endtask

  task automatic wait_done(int nblk);
    int w = 0;
    while ((done_n == 0 || q_blk.size() < nblk) && w < 300) begin
      @(negedge Clk);
      w++;
    end
    if (w >= 300) chk("done_timeout", 1'b0, 1'b1);
  endtask

  function automatic logic [511:0] seqblk(int start, int n);
    logic [511:0] r = '0;
    for (int i = 0; i < n; i++)
      r[511-8*i -: 8] = 8'(start + i);
    return r;
  endfunction

  typedef struct {
    string        name;
    int           start;
    int           n;
    int           nblk;
    logic [511:0] b1;
    logic         l1;
    logic [511:0] b2;
  } vec_t;

  vec_t vt[4];
  logic [511:0] abc_blk;

  initial begin
    abc_blk = (512'h61626380 << 480) | 512'h18;
    vt[0] = '{"abc", 'h61, 3, 1, abc_blk, 1'b1, '0};
    vt[1] = '{"empty", 0, 0, 1, 512'h80 << 504, 1'b1, '0};
    vt[2] = '{"len56", 0, 56, 2,
              seqblk(0, 56) | (512'h80 << 56), 1'b0, 512'h1C0};
    vt[3] = '{"len64", 0, 64, 2, seqblk(0, 64), 1'b0,
              (512'h80 << 504) | 512'h200};

    Reset      = 1'b1;
    InData     = '0;
    InValid    = 1'b0;
    InLast     = 1'b0;
    InEmpty    = 1'b0;
    ChunkReady = 1'b1;
    repeat (3) @(negedge Clk);
    chk("rst_inready", InReady, 1'b0);
    chk("rst_valid", ChunkValid, 1'b0);
    chk("rst_last", ChunkLast, 1'b0);
    chk("rst_done", MsgDone, 1'b0);
    chk("rst_chunk", Chunk, '0);
    Reset = 1'b0;
    @(negedge Clk);
    chk("post_rst_inready", InReady, 1'b1);

    for (int k = 0; k < 4; k++) begin
      clr();
      send_msg(vt[k].start, vt[k].n);
      chk({vt[k].name, "_lat0"}, ChunkValid, vt[k].n == 64);
      wait_done(vt[k].nblk);
      chk({vt[k].name, "_nblk"}, q_blk.size(), vt[k].nblk);
      if (q_blk.size() >= 1) begin
        chk({vt[k].name, "_b1"}, q_blk[0], vt[k].b1);
        chk({vt[k].name, "_l1"}, q_last[0], vt[k].l1);
      end
      if (vt[k].nblk == 2 && q_blk.size() >= 2) begin
        chk({vt[k].name, "_b2"}, q_blk[1], vt[k].b2);
        chk({vt[k].name, "_l2"}, q_last[1], 1'b1);
`ifdef SHA256_PADDER_STATS_EN
        chk({vt[k].name, "_cnt1"}, q_cnt[0], 0);
        chk({vt[k].name, "_cnt2"}, q_cnt[1], 1);
`endif
      end
      repeat (3) @(negedge Clk);
      chk({vt[k].name, "_done_t"}, done_cyc, hs_cyc + 1);
      chk({vt[k].name, "_done_n"}, done_n, 1);
      chk({vt[k].name, "_idle_rdy"}, InReady, 1'b1);
    end

    // Backpressure: block must hold still while downstream stalls
    begin
      logic [511:0] snap;
      logic         sl;
      int           w;
      clr();
      ChunkReady = 1'b0;
      send_msg('h61, 3);
      w = 0;
      while (!ChunkValid && w < 50) begin
        @(negedge Clk);
        w++;
      end
      chk("stall_valid", ChunkValid, 1'b1);
      snap = Chunk;
      sl   = ChunkLast;
      for (int i = 0; i < 10; i++) begin
        @(negedge Clk);
        chk("stall_chunk", Chunk, snap);
        chk("stall_last", ChunkLast, sl);
        chk("stall_inready", InReady, 1'b0);
        chk("stall_hold", ChunkValid, 1'b1);
      end
      chk("stall_nohs", q_blk.size(), 0);
      ChunkReady = 1'b1;
      wait_done(1);
      chk("stall_nblk", q_blk.size(), 1);
      if (q_blk.size() >= 1) begin
        chk("stall_blk", q_blk[0], abc_blk);
        chk("stall_l", q_last[0], 1'b1);
      end
      repeat (3) @(negedge Clk);
      chk("stall_done_n", done_n, 1);
    end

    // Reset mid-message discards the partial block
    clr();
    for (int i = 0; i < 20; i++)
      send_beat(8'(8'hA0 + i), 1'b0, 1'b0);
    @(negedge Clk);
    InValid = 1'b0;
    Reset   = 1'b1;
    @(negedge Clk);
    chk("mid_rst_inready", InReady, 1'b0);
    chk("mid_rst_valid", ChunkValid, 1'b0);
    Reset = 1'b0;
    @(negedge Clk);
    chk("mid_rel_inready", InReady, 1'b1);
    chk("mid_rel_valid", ChunkValid, 1'b0);
    send_msg('h61, 3);
    wait_done(1);
    chk("mid_nblk", q_blk.size(), 1);
    if (q_blk.size() >= 1)
      chk("mid_blk", q_blk[0], abc_blk);
    repeat (3) @(negedge Clk);
    chk("mid_done_n", done_n, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
